// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Waits a programmable settle time after a start pulse, snapshots the SIZE x SIZE
// product matrix of the systolic array, then streams it out row-major over a
// valid/ready interface with row/column indices and a last flag.
// Optional feature: define DRAIN_CHECKSUM_EN to add a modulo-2^WIDTH running sum
// of the streamed elements on the checksum output.
module systolic_result_drain #(
    parameter int WIDTH          = 16,
    parameter int SIZE           = 3,
    parameter int COMPUTE_CYCLES = 9,
    parameter int IDXW           = 2
) (
    input  logic                                  clock,
    input  logic                                  nreset,
    input  logic                                  start,
    input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  product_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0]                      out_data,
    output logic [IDXW-1:0]                       out_row,
    output logic [IDXW-1:0]                       out_col,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
`ifdef DRAIN_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]                      checksum
`endif
);

    // Counter only has to reach COMPUTE_CYCLES-1; keep at least one bit.
    localparam int CNTW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(COMPUTE_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    // Snapshot bank: decoupled from product_in once captured, so the array can
    // be reloaded with the next operands while this result drains.
    logic [WIDTH-1:0]  bank_q [SIZE][SIZE];

    // Output registers; out_row/out_col double as the drain pointers.
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [IDXW-1:0]   out_row_q,   out_row_d;
    logic [IDXW-1:0]   out_col_q,   out_col_d;
    logic              out_last_q,  out_last_d;
    logic              done_q,      done_d;

    logic              xfer;
    logic [IDXW-1:0]   row_nx;
    logic [IDXW-1:0]   col_nx;

    assign xfer = out_valid_q && out_ready;

    // Row-major successor of the element currently presented.
    assign col_nx = (out_col_q == IDX_LAST) ? '0 : out_col_q + 1'b1;
    assign row_nx = (out_col_q == IDX_LAST) ? out_row_q + 1'b1 : out_row_q;

    // State and settle-counter registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE, never queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (xfer && out_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One register per matrix element, loaded together during CAPTURE.
    generate
        for (genvar gi = 0; gi < SIZE * SIZE; gi++) begin : g_bank
            always_ff @(posedge clock or negedge nreset) begin
                if (!nreset) begin
                    bank_q[gi / SIZE][gi % SIZE] <= '0;
                end else if (state_q == S_CAPTURE) begin
                    bank_q[gi / SIZE][gi % SIZE] <= product_in[gi / SIZE][gi % SIZE];
                end
            end
        end
    endgenerate

    // Output next-state: first element loads on the first DRAIN cycle, later
    // elements load on each transfer so ready-high gives back-to-back beats.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        case (state_q)
            S_CAPTURE: begin
                out_valid_d = 1'b0;
                out_row_d   = '0;
                out_col_d   = '0;
                out_last_d  = 1'b0;
            end
            S_DRAIN: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bank_q[out_row_q][out_col_q];
                    out_last_d  = (out_row_q == IDX_LAST) && (out_col_q == IDX_LAST);
                end else if (xfer) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_row_d   = '0;
                        out_col_d   = '0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        out_row_d   = row_nx;
                        out_col_d   = col_nx;
                        out_data_d  = bank_q[row_nx][col_nx];
                        out_last_d  = (row_nx == IDX_LAST) && (col_nx == IDX_LAST);
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // Output registers; nothing here sees product_in directly.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

`ifdef DRAIN_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    // Sum clears as CAPTURE is entered and accumulates every accepted element.
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == S_COMPUTE) && (state_d == S_CAPTURE)) begin
            checksum_d = '0;
        end else if ((state_q == S_DRAIN) && xfer) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    // Checksum register; value persists after done until the next capture.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Testbench for systolic_result_drain: randomized jobs checked against a
// queue-based reference of the captured matrix.
module tb_systolic_result_drain;

    localparam int WIDTH = 16;
    localparam int SIZE  = 3;
    localparam int CC    = 9;
    localparam int IDXW  = 2;

    logic                                 clock = 1'b0;
    logic                                 nreset = 1'b0;
    logic                                 start = 1'b0;
    logic                                 out_ready = 1'b0;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] product_in = '0;
    logic                                 out_valid;
    logic [WIDTH-1:0]                     out_data;
    logic [IDXW-1:0]                      out_row;
    logic [IDXW-1:0]                      out_col;
    logic                                 out_last;
    logic                                 busy;
    logic                                 done;
`ifdef DRAIN_CHECKSUM_EN
    logic [WIDTH-1:0]                     checksum;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int               r;
        int               c;
        logic [WIDTH-1:0] d;
    } elem_t;

    systolic_result_drain #(
        .WIDTH(WIDTH), .SIZE(SIZE), .COMPUTE_CYCLES(CC), .IDXW(IDXW)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .start      (start),
        .product_in (product_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef DRAIN_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: 10*r+c, mode 1: random, mode 2: all 16'h8000
    task automatic fill(input int mode);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                case (mode)
                    0:       product_in[r][c] = WIDTH'(10 * r + c);
                    1:       product_in[r][c] = WIDTH'($urandom);
                    default: product_in[r][c] = 16'h8000;
                endcase
            end
        end
    endtask

    // One job: start pulse, settle, drain. rdy_mode 0: always ready,
    // 1: ready pattern 1,0,0, 2: random. abort_n>0 resets after that many transfers.
    task automatic run_job(input int mode, input int rdy_mode, input bit poke,
                           input int abort_n, input bit post_idle);
        elem_t            q[$];
        elem_t            e;
        logic [WIDTH-1:0] sum;
        int               popped;
        int               budget;
        bit               rdy;

        fill(mode);
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        sum = '0;
        // Cycles k = 0 .. CC+1 after the start edge: busy, nothing valid yet.
        for (int k = 0; k < CC + 2; k++) begin
            check("busy_compute", 32'(busy), 32'(1));
            check("valid_early", 32'(out_valid), 32'(0));
            start = (poke && k == 3);
            if (k == CC - 3 && mode == 1) fill(1);
            if (k == CC) begin
                // value present at the capture edge becomes the expected stream
                for (int r = 0; r < SIZE; r++) begin
                    for (int c = 0; c < SIZE; c++) begin
                        e.r = r; e.c = c; e.d = product_in[r][c];
                        q.push_back(e);
                        sum = sum + e.d;
                    end
                end
            end
            if (k == CC + 1) product_in = {SIZE*SIZE{16'hFFFF}};
            @(negedge clock);
        end
        start = 1'b0;
        popped = 0;
        budget = 0;
        while (q.size() > 0 && budget < 200) begin
            if (abort_n > 0 && popped == abort_n) begin
                nreset = 1'b0;
                #1;
                check("rst_valid", 32'(out_valid), 32'(0));
                check("rst_busy", 32'(busy), 32'(0));
                check("rst_done", 32'(done), 32'(0));
                check("rst_row", 32'(out_row), 32'(0));
                check("rst_col", 32'(out_col), 32'(0));
                check("rst_last", 32'(out_last), 32'(0));
                out_ready = 1'b0;
                @(negedge clock);
                nreset = 1'b1;
                return;
            end
            e = q[0];
            check("valid", 32'(out_valid), 32'(1));
            check("data", 32'(out_data), 32'(e.d));
            check("row", 32'(out_row), 32'(e.r));
            check("col", 32'(out_col), 32'(e.c));
            check("last", 32'(out_last), 32'(q.size() == 1));
            check("busy_drain", 32'(busy), 32'(1));
            check("done_early", 32'(done), 32'(0));
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (budget % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            start = (poke && popped == 2);
            out_ready = rdy;
            if (rdy) begin
                void'(q.pop_front());
                popped++;
            end
            @(negedge clock);
            budget++;
        end
        start = 1'b0;
        check("drain_timeout", 32'(q.size()), 32'(0));
        check("done_pulse", 32'(done), 32'(1));
        check("valid_after", 32'(out_valid), 32'(0));
        check("busy_after", 32'(busy), 32'(0));
`ifdef DRAIN_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(sum));
`endif
        if (post_idle) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("done_once", 32'(done), 32'(0));
                check("idle_busy", 32'(busy), 32'(0));
                check("idle_valid", 32'(out_valid), 32'(0));
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_valid", 32'(out_valid), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_data", 32'(out_data), 32'(0));
        check("reset_last", 32'(out_last), 32'(0));
        nreset = 1'b1;
        @(negedge clock);
        run_job(0, 0, 1'b0, 0, 1'b1);   // basic drain
        run_job(0, 1, 1'b0, 0, 1'b1);   // backpressure
        run_job(0, 0, 1'b1, 0, 1'b1);   // starts during COMPUTE and DRAIN ignored
        run_job(0, 0, 1'b0, 4, 1'b0);   // reset after 4 transfers
        run_job(0, 0, 1'b0, 0, 1'b0);   // full stream after reset
        run_job(2, 0, 1'b0, 0, 1'b0);   // back-to-back, checksum wrap
        for (int i = 0; i < 6; i++) begin
            run_job(1, 2, 1'($urandom_range(0, 1)), 0, 1'(i % 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
